// File: rtl/droid_pkg.sv
// Shared definitions for the droid command bus: opcode encodings, legality check,
// issuer state encoding and the 28-bit command record {op, data, loc}.
// Pure declarations, no logic.
package droid_pkg;

  localparam logic [3:0] OP_NOOP     = 4'b0000;
  localparam logic [3:0] OP_STANDBY  = 4'b0100;
  localparam logic [3:0] OP_ATTACK   = 4'b0101;
  localparam logic [3:0] OP_GOTO     = 4'b0110;
  localparam logic [3:0] OP_TARGET   = 4'b0111;
  localparam logic [3:0] OP_RANK     = 4'b1000;
  localparam logic [3:0] OP_BATTERY  = 4'b1001;
  localparam logic [3:0] OP_ATLOC    = 4'b1010;
  localparam logic [3:0] OP_RESET    = 4'b1100;
  localparam logic [3:0] OP_SHUTDOWN = 4'b1101;

  localparam int CMD_W = 28;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_GAP      = 3'd2,
    ST_POLL     = 3'd3,
    ST_WAIT_ALB = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  data;
    logic [15:0] loc;
  } cmd_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic ok;
    case (op)
      OP_NOOP, OP_STANDBY, OP_ATTACK, OP_GOTO, OP_TARGET,
      OP_RANK, OP_BATTERY, OP_ATLOC, OP_RESET, OP_SHUTDOWN: ok = 1'b1;
      default:                                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/droid_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x WIDTH, with flush; head is read combinationally.
// Latency: a push is visible at the head (empty_o low) after the pushing edge.
// Backpressure: push ignored when full (no write-through), pop ignored when empty; flush wins.
module droid_cmd_fifo
  import droid_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // pointers wrap naturally at DEPTH (power of two); flush empties in one cycle
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // storage array carries no reset; only entries below count are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/droid_cmd_issuer.sv
// Host-to-droid command issuer: queues host commands and issues them one at a time on a
// valid/ready bus, dropping undefined opcodes and letting RESET preempt everything queued.
// DROID_GOTO_WAIT_EN: when defined, each GOTO is followed by ATLOC polls until arrival/timeout.
module droid_cmd_issuer
  import droid_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int POLL_GAP  = 8,
  parameter int MAX_POLLS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_in_valid,
  output logic                   cmd_in_ready,
  input  logic [3:0]             cmd_in_opcode,
  input  logic [7:0]             cmd_in_data,
  input  logic [15:0]            cmd_in_loc,
  output logic                   droid_valid,
  input  logic                   droid_ready,
  output logic [3:0]             droid_opcode,
  output logic [7:0]             droid_data,
  output logic [15:0]            droid_loc,
  input  logic                   droid_alb,
  input  logic                   droid_alb_valid,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   illegal_op,
  output logic                   timeout_err
);

  localparam cmd_t CMD_IDLE  = '{op: OP_NOOP,  data: 8'h00, loc: 16'h0000};
  localparam cmd_t CMD_RESET = '{op: OP_RESET, data: 8'h00, loc: 16'h0000};

  state_t state_q, state_d;
  cmd_t   cmd_q, cmd_d, in_cmd, fifo_head;
  logic   valid_q, valid_d, illegal_q;
  logic   fifo_full, fifo_empty;
  logic   accept, in_legal, rst_cmd, push, pop, hs;

  assign in_cmd       = '{op: cmd_in_opcode, data: cmd_in_data, loc: cmd_in_loc};
  assign cmd_in_ready = ~fifo_full;
  assign accept       = cmd_in_valid & cmd_in_ready;
  assign in_legal     = is_legal_op(cmd_in_opcode);
  // RESET bypasses the queue entirely; NOOP is accepted and silently discarded
  assign rst_cmd      = accept & (cmd_in_opcode == OP_RESET);
  assign push         = accept & in_legal & (cmd_in_opcode != OP_NOOP) & (cmd_in_opcode != OP_RESET);
  assign pop          = (state_q == ST_IDLE) & ~fifo_empty & ~rst_cmd;
  assign hs           = valid_q & droid_ready;

  droid_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_cmd),
    .pop_i   (pop),
    .flush_i (rst_cmd),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef DROID_GOTO_WAIT_EN
  localparam int   GW        = $clog2(POLL_GAP) + 1;
  localparam int   PW        = $clog2(MAX_POLLS + 1);
  localparam cmd_t CMD_ATLOC = '{op: OP_ATLOC, data: 8'h00, loc: 16'h0000};

  logic [GW-1:0] gap_cnt_q;
  logic [PW-1:0] poll_cnt_q;
  logic          gap_done, alb_miss, poll_last, goto_hs, timeout_q;

  assign gap_done  = (state_q == ST_GAP) && (gap_cnt_q == GW'(POLL_GAP - 1));
  assign alb_miss  = (state_q == ST_WAIT_ALB) & droid_alb_valid & ~droid_alb;
  // this miss is the MAX_POLLS-th one
  assign poll_last = (poll_cnt_q == PW'(MAX_POLLS - 1));
  assign goto_hs   = (state_q == ST_ISSUE) & hs & (cmd_q.op == OP_GOTO);

  // gap timer restarts on every GAP entry; poll counter spans one GOTO's whole polling run
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt_q  <= '0;
      poll_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      gap_cnt_q <= (state_q == ST_GAP) ? gap_cnt_q + GW'(1) : '0;
      if (goto_hs)       poll_cnt_q <= '0;
      else if (alb_miss) poll_cnt_q <= poll_cnt_q + PW'(1);
      timeout_q <= alb_miss & poll_last & ~rst_cmd;
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_alb;
  assign unused_alb  = &{1'b0, droid_alb, droid_alb_valid, POLL_GAP[0], MAX_POLLS[0]};
  assign timeout_err = 1'b0;
`endif

  // state and bus output registers; illegal_op is a registered one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      cmd_q     <= CMD_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      cmd_q     <= cmd_d;
      illegal_q <= accept & ~in_legal;
    end
  end

  // next state: a RESET push overrides whatever the sequencer was doing
  always_comb begin
    state_d = state_q;
    if (rst_cmd) begin
      state_d = ST_ISSUE;
    end else begin
      case (state_q)
        ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
        ST_ISSUE: if (hs) begin
`ifdef DROID_GOTO_WAIT_EN
          state_d = (cmd_q.op == OP_GOTO) ? ST_GAP : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
`ifdef DROID_GOTO_WAIT_EN
        ST_GAP:      if (gap_done) state_d = ST_POLL;
        ST_POLL:     if (hs) state_d = ST_WAIT_ALB;
        ST_WAIT_ALB: if (droid_alb_valid) state_d = (droid_alb || poll_last) ? ST_IDLE : ST_GAP;
`endif
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // next bus contents: held stable while stalled, cleared to NOOP/0 after each handshake
  always_comb begin
    valid_d = valid_q;
    cmd_d   = cmd_q;
    if (rst_cmd) begin
      valid_d = 1'b1;
      cmd_d   = CMD_RESET;
    end else begin
      case (state_q)
        ST_IDLE: if (!fifo_empty) begin
          valid_d = 1'b1;
          cmd_d   = fifo_head;
        end
        ST_ISSUE: if (hs) begin
          valid_d = 1'b0;
          cmd_d   = CMD_IDLE;
        end
`ifdef DROID_GOTO_WAIT_EN
        ST_GAP: if (gap_done) begin
          valid_d = 1'b1;
          cmd_d   = CMD_ATLOC;
        end
        ST_POLL: if (hs) begin
          valid_d = 1'b0;
          cmd_d   = CMD_IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

  assign droid_valid  = valid_q;
  assign droid_opcode = cmd_q.op;
  assign droid_data   = cmd_q.data;
  assign droid_loc    = cmd_q.loc;
  assign illegal_op   = illegal_q;
  assign busy         = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_droid_cmd_issuer.sv
// Bench for droid_cmd_issuer: table of single-command vectors plus hand-written stall,
// overflow, RESET-preemption and (with DROID_GOTO_WAIT_EN) GOTO polling sequences.
// Issued bus commands are checked against a scoreboard queue filled when the host drives.
module tb_droid_cmd_issuer;
  import droid_pkg::*;

  localparam int DEPTH     = 4;
  localparam int POLL_GAP  = 8;
  localparam int MAX_POLLS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_in_valid = 1'b0, cmd_in_ready;
  logic [3:0]  cmd_in_opcode = '0;
  logic [7:0]  cmd_in_data = '0;
  logic [15:0] cmd_in_loc = '0;
  logic        droid_valid, droid_ready = 1'b0;
  logic [3:0]  droid_opcode;
  logic [7:0]  droid_data;
  logic [15:0] droid_loc;
  logic        droid_alb = 1'b0, droid_alb_valid = 1'b0;
  logic        busy, illegal_op, timeout_err;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  droid_cmd_issuer #(.DEPTH(DEPTH), .POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)) dut (
    .clk(clk), .rst(rst),
    .cmd_in_valid(cmd_in_valid), .cmd_in_ready(cmd_in_ready),
    .cmd_in_opcode(cmd_in_opcode), .cmd_in_data(cmd_in_data), .cmd_in_loc(cmd_in_loc),
    .droid_valid(droid_valid), .droid_ready(droid_ready),
    .droid_opcode(droid_opcode), .droid_data(droid_data), .droid_loc(droid_loc),
    .droid_alb(droid_alb), .droid_alb_valid(droid_alb_valid),
    .busy(busy), .fifo_count(fifo_count), .illegal_op(illegal_op), .timeout_err(timeout_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int atloc_seen = 0;
  int timeout_seen = 0;
  logic polling = 1'b0;
  logic [27:0] exp_q[$];
  logic [27:0] mon_got, mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every bus handshake must match the oldest expected command
  always @(negedge clk) begin
    if (!rst && droid_valid && droid_ready) begin
      mon_got = {droid_opcode, droid_data, droid_loc};
      if (polling && droid_opcode == 4'b1010) begin
        atloc_seen++;
        check("poll_spacing_ok", ((cyc - last_hs_cyc) >= POLL_GAP) ? 1 : 0, 1);
      end
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL issue_unexpected: got %h with empty scoreboard", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("issue_order", mon_got, mon_exp);
      end
    end
  end

  always @(negedge clk) if (!rst && timeout_err) timeout_seen++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // host model: what the droid bus should eventually carry for an accepted command
  task automatic model_accept(input logic [3:0] op, input logic [7:0] d, input logic [15:0] l);
    case (op)
      4'b1100: begin exp_q.delete(); exp_q.push_back({4'b1100, 8'h00, 16'h0000}); end
      4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000,
      4'b1001, 4'b1010, 4'b1101: exp_q.push_back({op, d, l});
      default: ;
    endcase
  endtask

  // drive one command for exactly one accepting edge; returns 1 ns after that edge
  task automatic send(input logic [3:0] op, input logic [7:0] d, input logic [15:0] l);
    int n = 0;
    while (!cmd_in_ready && n < 200) begin tick(1); n++; end
    if (!cmd_in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_ready: cmd_in_ready=0 after %0d cycles, expected 1", n);
    end else begin
      cmd_in_valid = 1'b1; cmd_in_opcode = op; cmd_in_data = d; cmd_in_loc = l;
      model_accept(op, d, l);
      tick(1);
      cmd_in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin tick(1); n++; end
    check(name, busy, 0);
  endtask

  task automatic wait_atloc(input string name);
    int n = 0;
    logic found = 1'b0;
    while (!found && n < 200) begin
      @(negedge clk);
      if (droid_valid && droid_ready && droid_opcode == 4'b1010) found = 1'b1;
      n++;
    end
    check(name, found, 1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  d;
    logic [15:0] l;
    logic        exp_ill;
    logic [2:0]  exp_cnt;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[15];
  logic [3:0] t2_ops[5];

  initial begin
    vecs[0]  = '{4'b0000, 8'h11, 16'h1111, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{4'b0001, 8'h00, 16'h0000, 1'b1, 3'd0, 1'b0};
    vecs[2]  = '{4'b0011, 8'h22, 16'h0022, 1'b1, 3'd0, 1'b0};
    vecs[3]  = '{4'b0100, 8'h01, 16'h0001, 1'b0, 3'd1, 1'b1};
    vecs[4]  = '{4'b0101, 8'h02, 16'h0002, 1'b0, 3'd1, 1'b1};
    vecs[5]  = '{4'b0111, 8'h00, 16'hBEEF, 1'b0, 3'd1, 1'b1};
    vecs[6]  = '{4'b1000, 8'h07, 16'h0000, 1'b0, 3'd1, 1'b1};
    vecs[7]  = '{4'b1001, 8'h64, 16'h0000, 1'b0, 3'd1, 1'b1};
    vecs[8]  = '{4'b1010, 8'h00, 16'h0042, 1'b0, 3'd1, 1'b1};
    vecs[9]  = '{4'b1011, 8'h33, 16'h3333, 1'b1, 3'd0, 1'b0};
    vecs[10] = '{4'b1100, 8'hAA, 16'h5555, 1'b0, 3'd0, 1'b1};
    vecs[11] = '{4'b1101, 8'h0D, 16'h000D, 1'b0, 3'd1, 1'b1};
    vecs[12] = '{4'b1110, 8'h00, 16'h0000, 1'b1, 3'd0, 1'b0};
    vecs[13] = '{4'b1111, 8'hFF, 16'hFFFF, 1'b1, 3'd0, 1'b0};
    vecs[14] = '{4'b0010, 8'h44, 16'h4444, 1'b1, 3'd0, 1'b0};
    t2_ops = '{4'b0100, 4'b0101, 4'b0111, 4'b1000, 4'b1001};

    // reset state
    tick(3);
    check("rst_valid", droid_valid, 0);
    check("rst_bus", {droid_opcode, droid_data, droid_loc}, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {illegal_op, timeout_err}, 0);
    check("rst_ready", cmd_in_ready, 1);
    rst = 1'b0;
    tick(1);

    // minimum latency: push at edge N, valid after edge N+1, idle after handshake
    droid_ready = 1'b1;
    send(4'b0100, 8'h00, 16'h0000);
    check("t1_not_yet_valid", droid_valid, 0);
    check("t1_count", fifo_count, 1);
    tick(1);
    check("t1_valid", droid_valid, 1);
    check("t1_opcode", droid_opcode, 4'b0100);
    check("t1_busy", busy, 1);
    tick(1);
    check("t1_valid_drop", droid_valid, 0);
    check("t1_opcode_noop", droid_opcode, 4'b0000);
    check("t1_busy_drop", busy, 0);

    // every opcode once: legality, queueing, pulse width
    for (int i = 0; i < 15; i++) begin
      send(vecs[i].op, vecs[i].d, vecs[i].l);
      check($sformatf("vec%0d_illegal", i), illegal_op, vecs[i].exp_ill);
      check($sformatf("vec%0d_count", i), fifo_count, vecs[i].exp_cnt);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      tick(1);
      check($sformatf("vec%0d_illegal_clear", i), illegal_op, 0);
      wait_idle($sformatf("vec%0d_idle", i));
    end
    check("vec_drained", exp_q.size(), 0);

    // stalled bus: one command on the bus plus DEPTH queued, then refusal
    droid_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(t2_ops[i], 8'(i), 16'hA000 + 16'(i));
    check("t2_full_ready", cmd_in_ready, 0);
    check("t2_full_count", fifo_count, 4);
    cmd_in_valid = 1'b1; cmd_in_opcode = 4'b1101; cmd_in_data = 8'h99; cmd_in_loc = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("t2_refused_count%0d", i), fifo_count, 4);
      check($sformatf("t2_hold_valid%0d", i), droid_valid, 1);
      check($sformatf("t2_hold_bus%0d", i), {droid_opcode, droid_data, droid_loc},
            {4'b0100, 8'h00, 16'hA000});
    end
    cmd_in_valid = 1'b0;
    droid_ready = 1'b1;
    wait_idle("t2_idle");
    check("t2_drained", exp_q.size(), 0);

`ifdef DROID_GOTO_WAIT_EN
    // GOTO followed by ATLOC polls, arrival on the third
    polling = 1'b1;
    send(4'b0110, 8'h00, 16'h1234);
    repeat (3) exp_q.push_back({4'b1010, 8'h00, 16'h0000});
    for (int p = 0; p < 3; p++) begin
      wait_atloc($sformatf("t4_atloc%0d", p));
      tick(2);
      droid_alb_valid = 1'b1; droid_alb = (p == 2);
      tick(1);
      droid_alb_valid = 1'b0; droid_alb = 1'b0;
    end
    check("t4_idle", busy, 0);
    check("t4_atloc_count", atloc_seen, 3);
    check("t4_no_timeout", timeout_seen, 0);
    check("t4_drained", exp_q.size(), 0);

    // droid never arrives: MAX_POLLS polls, timeout pulse, queued command proceeds
    send(4'b0110, 8'h00, 16'h4321);
    repeat (MAX_POLLS) exp_q.push_back({4'b1010, 8'h00, 16'h0000});
    send(4'b0100, 8'h5C, 16'h0000);
    for (int p = 0; p < MAX_POLLS; p++) begin
      wait_atloc($sformatf("t5_atloc%0d", p));
      tick(1);
      droid_alb_valid = 1'b1; droid_alb = 1'b0;
      tick(1);
      droid_alb_valid = 1'b0;
      check($sformatf("t5_timeout%0d", p), timeout_err, (p == MAX_POLLS - 1) ? 1 : 0);
    end
    tick(1);
    check("t5_timeout_clear", timeout_err, 0);
    check("t5_next_valid", droid_valid, 1);
    check("t5_next_opcode", droid_opcode, 4'b0100);
    wait_idle("t5_idle");
    check("t5_atloc_count", atloc_seen, 3 + MAX_POLLS);
    check("t5_timeout_count", timeout_seen, 1);
    check("t5_drained", exp_q.size(), 0);
    polling = 1'b0;
`else
    // without polling, GOTO is an ordinary command and alb strobes are ignored
    send(4'b0110, 8'h00, 16'h1234);
    tick(2);
    check("goto_plain_idle", busy, 0);
    droid_alb_valid = 1'b1; droid_alb = 1'b0;
    tick(3);
    droid_alb_valid = 1'b0;
    check("goto_plain_still_idle", busy, 0);
    check("goto_plain_no_timeout", timeout_seen, 0);
    check("goto_plain_drained", exp_q.size(), 0);
`endif

    // RESET preempts a stalled command and everything queued behind it
    droid_ready = 1'b0;
    send(4'b0101, 8'h01, 16'h0101);
    send(4'b1000, 8'h02, 16'h0202);
    send(4'b1101, 8'h03, 16'h0303);
    check("t6_count_before", fifo_count, 2);
    check("t6_valid_before", droid_valid, 1);
    send(4'b1100, 8'h5A, 16'hBEEF);
    check("t6_flushed", fifo_count, 0);
    check("t6_valid", droid_valid, 1);
    check("t6_bus", {droid_opcode, droid_data, droid_loc}, {4'b1100, 8'h00, 16'h0000});
    droid_ready = 1'b1;
    wait_idle("t6_idle");
    tick(5);
    check("t6_no_stale", droid_valid, 0);
    check("t6_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
